// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: data width, NOP encoding, fault codes, fetch FSM states.
// No logic; pure types and constants.
// No flow control of its own.
package rv32i_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    // IF/ID payload as one packed word so load/reset act on it as a unit
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction, its PC and PC+4 plus a valid bit.
// Latency: one cycle from load to outputs.
// Backpressure: the owner deasserts load to hold; flush clears valid and beats load.
module if_id_reg
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_pc4,
    output logic            valid,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4
);

    if_id_t payload;

    // Valid bit and payload: flush drops the entry but leaves the payload bits alone,
    // since nothing downstream looks at them while valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            payload <= '{inst: NOP_INST, pc: '0, pc4: '0};
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            payload <= '{inst: in_inst, pc: in_pc, pc4: in_pc4};
        end
    end

    assign out_inst = payload.inst;
    assign out_pc   = payload.pc;
    assign out_pc4  = payload.pc4;

endmodule

// File: rtl/rv32i_fetch.sv
// Instruction fetch: owns the PC, reads IM combinationally, registers the result for decode.
// Latency: one cycle PC -> id_*; one bubble after a taken redirect.
// Backpressure: id_ready low holds PC and IF/ID; a redirect still wins over a stall.
module rv32i_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [29:0]     im_addr,
    input  logic [XLEN-1:0] im_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [31:0]     fetch_count
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next_seq;
    logic [31:0]     pc_word;

    logic in_run;
    logic xfer;
    logic can_load;
    logic redir_ok;
    logic redir_bad;
    logic range_err;
    logic do_load;
    logic do_flush;

    assign im_addr     = pc[31:2];
    assign pc_word     = {2'b00, pc[31:2]};
    // Wraps silently at 2^32; the range check then sees the wrapped index.
    assign pc_next_seq = pc + 32'd4;

    // Fetch control, in priority order: redirect, range fault, load, hold.
    always_comb begin
        in_run    = (state == ST_RUN);
        xfer      = id_valid && id_ready;
        can_load  = !id_valid || id_ready;
        redir_ok  = in_run && redirect_valid && (redirect_pc[1:0] == 2'b00);
        redir_bad = in_run && redirect_valid && (redirect_pc[1:0] != 2'b00);
        range_err = in_run && !redirect_valid && can_load && (pc_word >= IMEM_LIMIT);
        do_load   = in_run && !redirect_valid && can_load && !range_err;
        do_flush  = redir_ok || redir_bad || range_err;
    end

    // PC, fault flags and RUN/HALT state. HALT is terminal until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            fault      <= 1'b0;
            fault_code <= FAULT_NONE;
        end else if (state == ST_RUN) begin
            if (redir_ok) begin
                pc <= redirect_pc;
            end else if (redir_bad) begin
                fault      <= 1'b1;
                fault_code <= FAULT_MISALIGN;
                state      <= ST_HALT;
            end else if (range_err) begin
                fault      <= 1'b1;
                fault_code <= FAULT_RANGE;
                state      <= ST_HALT;
            end else if (do_load) begin
                pc <= pc_next_seq;
            end
        end else begin
            state <= ST_HALT;
        end
    end

    // Handshake counter; a transfer in the same cycle as a redirect still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (xfer) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (do_load),
        .flush    (do_flush),
        .in_inst  (im_inst),
        .in_pc    (pc),
        .in_pc4   (pc_next_seq),
        .valid    (id_valid),
        .out_inst (id_inst),
        .out_pc   (id_pc),
        .out_pc4  (id_pc4)
    );

endmodule

// File: tb/tb_rv32i_fetch.sv
module tb_rv32i_fetch;

    localparam int IMEM_WORDS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] im_addr;
    logic [31:0] im_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    // instruction memory model, combinational read
    logic [31:0] mem [0:63];
    assign im_inst = mem[im_addr[5:0]];

    rv32i_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .im_addr        (im_addr),
        .im_inst        (im_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4),
        .fault          (fault),
        .fault_code     (fault_code),
        .fetch_count    (fetch_count)
    );

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } xfer_t;
    xfer_t exp_q[$];

    // reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_idpc;
    logic [31:0] m_pc4;
    logic        m_fault;
    logic [1:0]  m_code;
    logic        m_halt;
    logic [31:0] m_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_inst  = 32'h0000_0013;
        m_idpc  = 32'h0;
        m_pc4   = 32'h0;
        m_fault = 1'b0;
        m_code  = 2'b00;
        m_halt  = 1'b0;
        m_count = 32'h0;
    endtask

    // one clock edge of the fetch stage, following the priority rules
    task automatic model_edge(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic want;
        if (m_valid && rdy) m_count = m_count + 1;
        if (!m_halt) begin
            want = !m_valid || rdy;
            if (rv) begin
                m_valid = 1'b0;
                if (rpc % 4 == 0) begin
                    m_pc = rpc;
                end else begin
                    m_fault = 1'b1;
                    m_code  = 2'b01;
                    m_halt  = 1'b1;
                end
            end else if (want && (m_pc / 4) >= IMEM_WORDS) begin
                m_valid = 1'b0;
                m_fault = 1'b1;
                m_code  = 2'b10;
                m_halt  = 1'b1;
            end else if (want) begin
                m_inst  = mem[m_pc / 4];
                m_idpc  = m_pc;
                m_pc4   = m_pc + 4;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
            end
        end
    endtask

    // called just after a rising edge; returns just after the next one
    task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        if (m_valid && rdy) exp_q.push_back('{m_inst, m_idpc, m_pc4});
        @(posedge clk);
        model_edge(rv, rpc, rdy);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #2;
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_id_inst", id_inst, 32'h0000_0013);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_pc4", id_pc4, 32'h0);
        check("rst_fault", {fault_code, 29'h0, fault}, 32'h0);
        check("rst_fetch_count", fetch_count, 32'h0);
        check("rst_im_addr", {2'b00, im_addr}, 32'h0);
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        model_reset();
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // monitor: every cycle compares status to the model, and pops the scoreboard on handshakes
    always @(negedge clk) begin
        if (mon_en) begin
            xfer_t e;
            check("id_valid", 32'(id_valid), 32'(m_valid));
            check("im_addr", {2'b00, im_addr}, {2'b00, m_pc[31:2]});
            check("fault", {fault_code, 29'h0, fault}, {m_code, 29'h0, m_fault});
            check("fetch_count", fetch_count, m_count);
            if (m_valid) check("id_pc_hold", id_pc, m_idpc);
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_xfer: unexpected transfer id_pc=%h, expected none", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_inst", id_inst, e.inst);
                    check("sb_pc", id_pc, e.pc);
                    check("sb_pc4", id_pc4, e.pc4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rpc;
        logic [31:0] last_pc;
        logic        rv;
        logic        rdy;

        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0030_0413;
        mem[1] = 32'h0010_0493;
        model_reset();
        #1;
        do_reset();

        // straight-line fetch from reset
        drive(1'b0, 32'h0, 1'b1);
        check("c1_inst", id_inst, 32'h0030_0413);
        check("c1_pc", id_pc, 32'h0);
        check("c1_pc4", id_pc4, 32'h4);
        drive(1'b0, 32'h0, 1'b1);
        check("c2_inst", id_inst, 32'h0010_0493);
        check("c2_pc", id_pc, 32'h4);
        drive(1'b0, 32'h0, 1'b1);
        check("c3_pc", id_pc, 32'h8);
        check("c3_count", fetch_count, 32'd2);

        // stall three cycles on id_pc=8
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0);
            check("stall_pc", id_pc, 32'h8);
            check("stall_im_addr", {2'b00, im_addr}, 32'd3);
            check("stall_count", fetch_count, 32'd2);
        end
        drive(1'b0, 32'h0, 1'b1);
        check("release_pc", id_pc, 32'hC);

        // redirect during a stall
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h34, 1'b0);
        check("redir_bubble", 32'(id_valid), 32'h0);
        check("redir_im_addr", {2'b00, im_addr}, 32'd13);
        drive(1'b0, 32'h0, 1'b0);
        check("redir_pc", id_pc, 32'h34);
        check("redir_inst", id_inst, mem[13]);

        // randomized traffic with redirects, stalls and occasional faults
        for (int i = 0; i < 600; i++) begin
            if (m_halt) do_reset();
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = 32'($urandom_range(0, 31)) << 2;
            if ($urandom_range(0, 9) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) rpc = rpc | 32'h80;
            drive(rv, rpc, rdy);
        end

        // reset asserted between edges during a stall
        do_reset();
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        do_reset();

        // sequential run off the end of IM
        last_pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 100 && !fault; i++) begin
            drive(1'b0, 32'h0, 1'b1);
            if (id_valid) last_pc = id_pc;
        end
        check("seq_last_pc", last_pc, 32'h7C);
        check("seq_code", 32'(fault_code), 32'h2);
        check("seq_count", fetch_count, 32'd32);
        check("seq_valid", 32'(id_valid), 32'h0);

        // misaligned redirect halts; later redirects ignored
        do_reset();
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h36, 1'b1);
        check("mis_fault", 32'(fault), 32'h1);
        check("mis_code", 32'(fault_code), 32'h1);
        check("mis_valid", 32'(id_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0, 1'b1);
            check("halt_im_addr", {2'b00, im_addr}, 32'd2);
            check("halt_code", 32'(fault_code), 32'h1);
        end

        // redirect to the top word: fetch index is far out of range
        do_reset();
        drive(1'b1, 32'hFFFF_FFFC, 1'b1);
        drive(1'b0, 32'h0, 1'b1);
        check("top_code", 32'(fault_code), 32'h2);
        check("top_valid", 32'(id_valid), 32'h0);

        drive(1'b0, 32'h0, 1'b1);
        mon_en = 1'b0;
        check("final_drain", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32i_fetch.md
# rv32i_fetch

Instruction-fetch stage of the rv32i datapath, directly upstream of the instruction memory (IM). It owns the program counter and drives the word address (PC[31:2]) into IM. It captures IM's combinational read data into an IF/ID register and hands it to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute and detects fetch faults.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `IMEM_WORDS`, default 32: number of valid IM words. Fetches at word index ≥ IMEM_WORDS fault.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `im_addr`  out  30  word address to IM; always equals PC[31:2].
- `im_inst`  in  32  IM read data; combinational from `im_addr`, valid in the same cycle.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  32  target byte address; sampled only when `redirect_valid`=1.
- `id_valid`  out  1  IF/ID holds an instruction for decode.
- `id_ready`  in  1  decode accepts this cycle.
- `id_inst`  out  32  fetched instruction.
- `id_pc`  out  32  byte address of `id_inst`.
- `id_pc4`  out  32  `id_pc` + 4, modulo 2^32.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  fault cause: 00 none, 01 misaligned redirect, 10 out-of-range fetch.
- `fetch_count`  out  32  count of completed handshakes; wraps.

## Operation
- State machine with two states: RUN and HALT. Reset enters RUN.
- Handshake: a transfer occurs when `id_valid` && `id_ready`.
- Load condition: `load = !id_valid || id_ready`.
- Priority, evaluated at each edge in RUN:
  1. Redirect.
  2. Out-of-range check.
  3. Load.
  4. Hold.
- Redirect:
  - Aligned target (`redirect_pc[1:0]`==0): PC ← `redirect_pc` and `id_valid` ← 0 (flush), regardless of `id_ready`. The flushed instruction does not count as a handshake.
  - Misaligned target: `fault` ← 1, `fault_code` ← 01, `id_valid` ← 0, PC unchanged, next state HALT.
- Out-of-range: if `load` and PC[31:2] ≥ IMEM_WORDS, then `fault` ← 1, `fault_code` ← 10, `id_valid` ← 0, next state HALT. IM data is not captured.
- Load: `id_inst` ← `im_inst`, `id_pc` ← PC, `id_pc4` ← PC+4, `id_valid` ← 1, PC ← PC+4.
- Hold (`id_valid` && !`id_ready`): PC and the IF/ID register are unchanged.
- HALT:
  - No fetches; redirects are ignored.
  - `id_valid` stays 0.
  - `fault` and `fault_code` are sticky; only reset clears them.
- `fetch_count` increments on every handshake, including in the cycle a redirect arrives if a handshake also occurs in that cycle.

## Timing
- Reset values (applied asynchronously):
  - PC = RESET_PC
  - `id_valid` = 0
  - `id_inst` = 32'h0000_0013 (NOP)
  - `id_pc` = 0
  - `id_pc4` = 0
  - `fault` = 0
  - `fault_code` = 00
  - `fetch_count` = 0
  - state = RUN
- First edge after `rst_n` rises: IF/ID captures IM[RESET_PC>>2]. Fetch latency is one cycle from PC to `id_*`.
- Throughput: one instruction per cycle while `id_ready`=1.
- Redirect penalty: one bubble cycle (`id_valid`=0), then the target instruction is presented.
- Redirect in the same cycle as a stall: the redirect wins and the held instruction is dropped.
- PC+4 wraps at 2^32 without error. The out-of-range check catches the wrapped index.
- Reset asserted mid-stall or mid-redirect: all outputs take reset values immediately; there is no pending state.
- The outputs (`id_valid`, `id_inst`, `id_pc`, `id_pc4`, `fault`, `fault_code`, `fetch_count`) are registered. `im_addr` is a direct function of the PC register.

## Structure
- The shared package `rv32i_pkg` holds:
  - XLEN = 32
  - NOP encoding 32'h0000_0013
  - fault-code constants
  - the fetch state enum (RUN, HALT)
- One sub-module, `if_id_reg`: the IF/ID payload register with load/flush controls and NOP reset value.
- The PC, FSM, fault logic and counter live in the top.

## Test plan
- IM[0]=0x00300413, IM[1]=0x00100493; release reset with `id_ready`=1 → cycle 1: `id_inst`=0x00300413, `id_pc`=0, `id_pc4`=4; cycle 2: `id_inst`=0x00100493, `id_pc`=4; `fetch_count`=2 after cycle 2.
- Hold `id_ready`=0 for 3 cycles while `id_pc`=0x8 → `id_*` stable, `im_addr`=3, `fetch_count` unchanged; on release, next `id_pc`=0xC.
- With `id_ready`=0, pulse `redirect_valid`, `redirect_pc`=0x34 → next cycle `id_valid`=0 and `im_addr`=13; following cycle `id_pc`=0x34, `id_inst`=IM[13].
- `redirect_pc`=0x36 → `fault`=1, `fault_code`=01, `id_valid`=0; a later redirect to 0x0 is ignored and `im_addr` does not move.
- Sequential run from 0 with IMEM_WORDS=32 → last valid `id_pc`=0x7C; PC=0x80 gives `fault_code`=10; `fetch_count`=32.
- Assert `rst_n`=0 between edges during a stall → `id_valid`=0, `id_inst`=0x00000013, PC=RESET_PC before the next edge.
